// File: rtl/can_bus_arbiter_if.sv
// Requester and SJA1000 bus signals shared between the arbiter and its environment.
// Lock inputs exist only when CAN_ARB_LOCK_EN is defined.
interface can_bus_arbiter_if;
  logic       R0_REQ, R0_WE, R0_CHIP;
  logic [7:0] R0_ADDR, R0_WDATA;
  logic       R0_GNT, R0_DONE;
  logic       R1_REQ, R1_WE, R1_CHIP;
  logic [7:0] R1_ADDR, R1_WDATA;
  logic       R1_GNT, R1_DONE;
`ifdef CAN_ARB_LOCK_EN
  logic       R0_LOCK, R1_LOCK;
`endif
  logic [7:0] RDATA;
  logic [7:0] CAN_AD_O, CAN_AD_I;
  logic       CAN_AD_OE, CAN_ALE, CAN_RD_N, CAN_WR_N;
  logic       CAN_CS1_N, CAN_CS2_N, CAN_BUF_DIR;

  modport slave (
    input  R0_REQ, R0_WE, R0_CHIP, R0_ADDR, R0_WDATA,
    input  R1_REQ, R1_WE, R1_CHIP, R1_ADDR, R1_WDATA,
`ifdef CAN_ARB_LOCK_EN
    input  R0_LOCK, R1_LOCK,
`endif
    input  CAN_AD_I,
    output R0_GNT, R0_DONE, R1_GNT, R1_DONE, RDATA,
    output CAN_AD_O, CAN_AD_OE, CAN_ALE, CAN_RD_N, CAN_WR_N,
    output CAN_CS1_N, CAN_CS2_N, CAN_BUF_DIR
  );

  modport master (
    output R0_REQ, R0_WE, R0_CHIP, R0_ADDR, R0_WDATA,
    output R1_REQ, R1_WE, R1_CHIP, R1_ADDR, R1_WDATA,
`ifdef CAN_ARB_LOCK_EN
    output R0_LOCK, R1_LOCK,
`endif
    output CAN_AD_I,
    input  R0_GNT, R0_DONE, R1_GNT, R1_DONE, RDATA,
    input  CAN_AD_O, CAN_AD_OE, CAN_ALE, CAN_RD_N, CAN_WR_N,
    input  CAN_CS1_N, CAN_CS2_N, CAN_BUF_DIR
  );
endinterface

// File: rtl/can_bus_arbiter.sv
// Two-requester round-robin arbiter driving one SJA1000 multiplexed AD bus cycle per grant.
// GNT to DONE takes ALE_CYC+STRB_CYC+HOLD_CYC cycles; CAN_ARB_LOCK_EN adds per-requester bus locking.
module can_bus_arbiter #(
  parameter int unsigned ALE_CYC  = 1,
  parameter int unsigned STRB_CYC = 3,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic             OPB_CLK,
  input  logic             OPB_RST_N,
  can_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SETUP, S_STRB, S_HOLD} state_t;

  localparam logic [3:0] ALE_LD  = 4'(ALE_CYC);
  localparam logic [3:0] STRB_LD = 4'(STRB_CYC);
  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       we_q, we_d;
  logic       chip_q, chip_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       win;
  logic       last_cyc;
  logic       cs_act;
`ifdef CAN_ARB_LOCK_EN
  logic [1:0] lock_q, lock_d;
`endif

  assign last_cyc = (cnt_q == 4'd1);

  // On a tie the requester that was not served last wins; a held lock overrides.
  always_comb begin
    if (bus.R0_REQ && bus.R1_REQ) begin
      win = ~last_q;
    end else begin
      win = bus.R1_REQ;
    end
`ifdef CAN_ARB_LOCK_EN
    if (lock_q[0] && bus.R0_REQ) begin
      win = 1'b0;
    end else if (lock_q[1] && bus.R1_REQ) begin
      win = 1'b1;
    end
`endif
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      chip_q  <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
`ifdef CAN_ARB_LOCK_EN
      lock_q  <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      chip_q  <= chip_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef CAN_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    chip_d  = chip_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef CAN_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef CAN_ARB_LOCK_EN
        lock_d = 2'b00;
`endif
        if (bus.R0_REQ || bus.R1_REQ) begin
          owner_d = win;
          last_d  = win;
          we_d    = win ? bus.R1_WE    : bus.R0_WE;
          chip_d  = win ? bus.R1_CHIP  : bus.R0_CHIP;
          addr_d  = win ? bus.R1_ADDR  : bus.R0_ADDR;
          wdata_d = win ? bus.R1_WDATA : bus.R0_WDATA;
          cnt_d   = ALE_LD;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (last_cyc) begin
          cnt_d   = 4'd0;
          state_d = S_SETUP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SETUP: begin
        cnt_d   = STRB_LD;
        state_d = S_STRB;
      end
      S_STRB: begin
        if (last_cyc) begin
          if (!we_q) begin
            rdata_d = bus.CAN_AD_I;
          end
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (last_cyc) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
`ifdef CAN_ARB_LOCK_EN
          lock_d  = owner_q ? {bus.R1_LOCK, 1'b0} : {1'b0, bus.R0_LOCK};
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.R0_GNT      = 1'b0;
    bus.R1_GNT      = 1'b0;
    bus.R0_DONE     = 1'b0;
    bus.R1_DONE     = 1'b0;
    bus.RDATA       = rdata_q;
    bus.CAN_ALE     = 1'b0;
    bus.CAN_RD_N    = 1'b1;
    bus.CAN_WR_N    = 1'b1;
    bus.CAN_AD_OE   = 1'b0;
    bus.CAN_AD_O    = 8'h00;
    bus.CAN_BUF_DIR = 1'b0;
    cs_act          = 1'b0;
    if (state_q != S_IDLE) begin
      bus.R0_GNT = ~owner_q;
      bus.R1_GNT = owner_q;
    end
    case (state_q)
      S_ADDR: begin
        bus.CAN_ALE   = 1'b1;
        bus.CAN_AD_OE = 1'b1;
        bus.CAN_AD_O  = addr_q;
      end
      S_SETUP: begin
        bus.CAN_AD_OE = 1'b1;
        bus.CAN_AD_O  = addr_q;
      end
      S_STRB: begin
        cs_act = 1'b1;
        if (we_q) begin
          bus.CAN_WR_N  = 1'b0;
          bus.CAN_AD_OE = 1'b1;
          bus.CAN_AD_O  = wdata_q;
        end else begin
          bus.CAN_RD_N    = 1'b0;
          bus.CAN_BUF_DIR = 1'b1;
        end
      end
      S_HOLD: begin
        cs_act = 1'b1;
        if (we_q) begin
          bus.CAN_AD_OE = 1'b1;
          bus.CAN_AD_O  = wdata_q;
        end
        bus.R0_DONE = last_cyc & ~owner_q;
        bus.R1_DONE = last_cyc & owner_q;
      end
      default: begin
        cs_act = 1'b0;
      end
    endcase
    bus.CAN_CS1_N = ~(cs_act & ~chip_q);
    bus.CAN_CS2_N = ~(cs_act & chip_q);
  end

endmodule

// File: tb/tb_can_bus_arbiter.sv
// Directed bench for can_bus_arbiter: table of single transactions plus arbitration,
// reset-abort, lock (when CAN_ARB_LOCK_EN is defined) and short-timing sequences.
module tb_can_bus_arbiter;
  localparam int A_LAT = 1 + 1 + 3 + 1 - 1;
  localparam int B_LAT = 2 + 1 + 1 + 1 - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  can_bus_arbiter_if bus_a ();
  can_bus_arbiter_if bus_b ();

  can_bus_arbiter u_a (.OPB_CLK(clk), .OPB_RST_N(rst_n), .bus(bus_a.slave));
  can_bus_arbiter #(.ALE_CYC(2), .STRB_CYC(1), .HOLD_CYC(1))
    u_b (.OPB_CLK(clk), .OPB_RST_N(rst_n), .bus(bus_b.slave));

  typedef struct packed {
    bit         req;
    bit         we;
    bit         chip;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] adi;
    logic [7:0] exp_rdata;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int inv_bad_a = 0;
  int inv_bad_b = 0;

  always @(negedge clk) begin
    if ((!bus_a.CAN_RD_N && !bus_a.CAN_WR_N) || (!bus_a.CAN_CS1_N && !bus_a.CAN_CS2_N) ||
        (!bus_a.CAN_RD_N && bus_a.CAN_AD_OE))
      inv_bad_a++;
    if ((!bus_b.CAN_RD_N && !bus_b.CAN_WR_N) || (!bus_b.CAN_CS1_N && !bus_b.CAN_CS2_N) ||
        (!bus_b.CAN_RD_N && bus_b.CAN_AD_OE))
      inv_bad_b++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic gnt_a(input bit r);
    return r ? bus_a.R1_GNT : bus_a.R0_GNT;
  endfunction

  function automatic logic done_a(input bit r);
    return r ? bus_a.R1_DONE : bus_a.R0_DONE;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    bit   got = 1'b0;
    int   ale_n = 0, ale_bad = 0, strb_n = 0, cs_n = 0, cs_bad = 0, dat_bad = 0, gnt_bad = 0;
    int   done_t = -1;
    logic [7:0] rd = 8'h00;
    logic cs_sel, cs_oth;
    @(negedge clk);
    bus_a.CAN_AD_I = v.adi;
    if (v.req) begin
      bus_a.R1_REQ = 1'b1; bus_a.R1_WE = v.we; bus_a.R1_CHIP = v.chip;
      bus_a.R1_ADDR = v.addr; bus_a.R1_WDATA = v.wdata;
    end else begin
      bus_a.R0_REQ = 1'b1; bus_a.R0_WE = v.we; bus_a.R0_CHIP = v.chip;
      bus_a.R0_ADDR = v.addr; bus_a.R0_WDATA = v.wdata;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt_a(v.req)) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("v%0d_grant", idx), 32'(got), 32'd1);
    for (int t = 0; t < 20 && got; t++) begin
      if (t > 0) @(negedge clk);
      cs_sel = v.chip ? bus_a.CAN_CS2_N : bus_a.CAN_CS1_N;
      cs_oth = v.chip ? bus_a.CAN_CS1_N : bus_a.CAN_CS2_N;
      if (!gnt_a(v.req) || gnt_a(!v.req) || done_a(!v.req)) gnt_bad++;
      if (bus_a.CAN_ALE) begin
        ale_n++;
        if (!(bus_a.CAN_AD_OE && bus_a.CAN_AD_O == v.addr)) ale_bad++;
      end
      if (v.we) begin
        if (!bus_a.CAN_WR_N) begin
          strb_n++;
          if (!(bus_a.CAN_AD_OE && bus_a.CAN_AD_O == v.wdata)) dat_bad++;
        end
        if (!bus_a.CAN_RD_N) dat_bad++;
      end else begin
        if (!bus_a.CAN_RD_N) begin
          strb_n++;
          if (bus_a.CAN_AD_OE || !bus_a.CAN_BUF_DIR) dat_bad++;
        end
        if (!bus_a.CAN_WR_N) dat_bad++;
      end
      if (!cs_sel) cs_n++;
      if (!cs_oth) cs_bad++;
      if (t == 0) begin
        if (v.req) begin
          bus_a.R1_REQ = 1'b0; bus_a.R1_WE = ~v.we; bus_a.R1_CHIP = ~v.chip;
          bus_a.R1_ADDR = ~v.addr; bus_a.R1_WDATA = ~v.wdata;
        end else begin
          bus_a.R0_REQ = 1'b0; bus_a.R0_WE = ~v.we; bus_a.R0_CHIP = ~v.chip;
          bus_a.R0_ADDR = ~v.addr; bus_a.R0_WDATA = ~v.wdata;
        end
      end
      if (done_a(v.req)) begin
        done_t = t;
        rd = bus_a.RDATA;
        break;
      end
    end
    check($sformatf("v%0d_ale_cycles", idx), 32'(ale_n), 32'd1);
    check($sformatf("v%0d_ale_addr", idx), 32'(ale_bad), 32'd0);
    check($sformatf("v%0d_strobe_cycles", idx), 32'(strb_n), 32'd3);
    check($sformatf("v%0d_cs_cycles", idx), 32'(cs_n), 32'd4);
    check($sformatf("v%0d_other_cs", idx), 32'(cs_bad), 32'd0);
    check($sformatf("v%0d_data_phase", idx), 32'(dat_bad), 32'd0);
    check($sformatf("v%0d_grant_stable", idx), 32'(gnt_bad), 32'd0);
    check($sformatf("v%0d_done_latency", idx), 32'(done_t), 32'(A_LAT));
    check($sformatf("v%0d_rdata", idx), 32'(rd), 32'(v.exp_rdata));
    @(negedge clk);
    check($sformatf("v%0d_idle_after", idx),
          32'({bus_a.R0_GNT, bus_a.R1_GNT, bus_a.R0_DONE, bus_a.R1_DONE}), 32'd0);
  endtask

  task automatic collect(input int n_want, input bit lock_mode,
                         output int n_got, output int gap_bad, output bit [7:0] owners);
    int gap = 0;
    int r1_cnt = 0;
    bit prev = 1'b0;
    bit g0, g1;
    n_got = 0;
    gap_bad = 0;
    owners = '0;
    for (int c = 0; c < 100 && n_got < n_want; c++) begin
      @(negedge clk);
      g0 = bus_a.R0_GNT;
      g1 = bus_a.R1_GNT;
      if ((g0 || g1) && !prev) begin
        owners[n_got] = g1;
        if (n_got > 0 && gap != 1) gap_bad++;
        n_got++;
        gap = 0;
        if (g1) r1_cnt++;
`ifdef CAN_ARB_LOCK_EN
        if (lock_mode && r1_cnt == 3) bus_a.R1_LOCK = 1'b0;
`endif
      end else if (!(g0 || g1)) begin
        gap++;
      end
      prev = g0 || g1;
    end
    if (lock_mode && r1_cnt > 8) gap_bad++;
  endtask

  vec_t vecs[5];

  initial begin
    int         n_got, gap_bad, done_seen, done_t, ale_n, strb_n;
    bit [7:0]   owners;
    bit         got;

    vecs[0] = '{req:1'b0, we:1'b1, chip:1'b0, addr:8'h0A, wdata:8'h5C, adi:8'h00, exp_rdata:8'h00};
    vecs[1] = '{req:1'b1, we:1'b0, chip:1'b1, addr:8'h02, wdata:8'h00, adi:8'hA7, exp_rdata:8'hA7};
    vecs[2] = '{req:1'b0, we:1'b0, chip:1'b0, addr:8'hFF, wdata:8'h11, adi:8'h3C, exp_rdata:8'h3C};
    vecs[3] = '{req:1'b1, we:1'b1, chip:1'b1, addr:8'h80, wdata:8'hC3, adi:8'h99, exp_rdata:8'h3C};
    vecs[4] = '{req:1'b0, we:1'b1, chip:1'b1, addr:8'h00, wdata:8'hFF, adi:8'h55, exp_rdata:8'h3C};

    bus_a.R0_REQ = 0; bus_a.R0_WE = 0; bus_a.R0_CHIP = 0; bus_a.R0_ADDR = 0; bus_a.R0_WDATA = 0;
    bus_a.R1_REQ = 0; bus_a.R1_WE = 0; bus_a.R1_CHIP = 0; bus_a.R1_ADDR = 0; bus_a.R1_WDATA = 0;
    bus_a.CAN_AD_I = 0;
    bus_b.R0_REQ = 0; bus_b.R0_WE = 0; bus_b.R0_CHIP = 0; bus_b.R0_ADDR = 0; bus_b.R0_WDATA = 0;
    bus_b.R1_REQ = 0; bus_b.R1_WE = 0; bus_b.R1_CHIP = 0; bus_b.R1_ADDR = 0; bus_b.R1_WDATA = 0;
    bus_b.CAN_AD_I = 0;
`ifdef CAN_ARB_LOCK_EN
    bus_a.R0_LOCK = 0; bus_a.R1_LOCK = 0; bus_b.R0_LOCK = 0; bus_b.R1_LOCK = 0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ctrl",
          32'({bus_a.R0_GNT, bus_a.R1_GNT, bus_a.R0_DONE, bus_a.R1_DONE, bus_a.CAN_ALE,
               bus_a.CAN_RD_N, bus_a.CAN_WR_N, bus_a.CAN_CS1_N, bus_a.CAN_CS2_N,
               bus_a.CAN_AD_OE, bus_a.CAN_BUF_DIR}), 32'b00000_1111_00);
    check("reset_ad_o", 32'(bus_a.CAN_AD_O), 32'h00);
    check("reset_rdata", 32'(bus_a.RDATA), 32'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

    // Both requesters held continuously from reset
    do_reset();
    bus_a.R0_REQ = 1'b1; bus_a.R0_WE = 1'b1; bus_a.R0_ADDR = 8'h10; bus_a.R0_WDATA = 8'h20;
    bus_a.R1_REQ = 1'b1; bus_a.R1_WE = 1'b0; bus_a.R1_ADDR = 8'h30;
    collect(4, 1'b0, n_got, gap_bad, owners);
    bus_a.R0_REQ = 1'b0; bus_a.R1_REQ = 1'b0;
    check("rr_grants", 32'(n_got), 32'd4);
    check("rr_order", 32'(owners[3:0]), 32'b1010);
    check("rr_idle_gap", 32'(gap_bad), 32'd0);
    repeat (10) @(negedge clk);

    // Reset during the strobe of a write after R0 was served last
    got = 1'b0;
    bus_a.R0_REQ = 1'b1; bus_a.R0_WE = 1'b1; bus_a.R0_CHIP = 1'b0;
    bus_a.R0_ADDR = 8'h44; bus_a.R0_WDATA = 8'h66;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.R0_GNT) bus_a.R0_REQ = 1'b0;
      if (!bus_a.CAN_WR_N) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_reached_strobe", 32'(got), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_strobes",
          32'({bus_a.CAN_ALE, bus_a.CAN_RD_N, bus_a.CAN_WR_N, bus_a.CAN_CS1_N, bus_a.CAN_CS2_N,
               bus_a.CAN_AD_OE, bus_a.CAN_BUF_DIR, bus_a.R0_GNT}), 32'b0111_1000);
    check("abort_ad_o", 32'(bus_a.CAN_AD_O), 32'h00);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus_a.R0_DONE || bus_a.R1_DONE) done_seen++;
    end
    rst_n = 1'b1;
    bus_a.R0_REQ = 1'b1; bus_a.R1_REQ = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_a.R0_DONE || bus_a.R1_DONE) done_seen++;
      if (bus_a.R0_GNT || bus_a.R1_GNT) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_first_grant_r0", 32'({got, bus_a.R0_GNT, bus_a.R1_GNT}), 32'b110);
    bus_a.R0_REQ = 1'b0; bus_a.R1_REQ = 1'b0;
    repeat (10) @(negedge clk);

`ifdef CAN_ARB_LOCK_EN
    do_reset();
    bus_a.R1_REQ = 1'b1; bus_a.R1_LOCK = 1'b1;
    @(posedge clk);
    #1 bus_a.R0_REQ = 1'b1;
    collect(4, 1'b1, n_got, gap_bad, owners);
    bus_a.R0_REQ = 1'b0; bus_a.R1_REQ = 1'b0; bus_a.R1_LOCK = 1'b0;
    check("lock_grants", 32'(n_got), 32'd4);
    check("lock_order", 32'(owners[3:0]), 32'b0111);
    check("lock_idle_gap", 32'(gap_bad), 32'd0);
    repeat (10) @(negedge clk);
`endif

    // Short strobe / long ALE instance
    @(negedge clk);
    bus_b.R0_REQ = 1'b1; bus_b.R0_WE = 1'b1; bus_b.R0_CHIP = 1'b1;
    bus_b.R0_ADDR = 8'h33; bus_b.R0_WDATA = 8'h44;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_b.R0_GNT) begin
        got = 1'b1;
        break;
      end
    end
    check("b_grant", 32'(got), 32'd1);
    bus_b.R0_REQ = 1'b0;
    done_t = -1; ale_n = 0; strb_n = 0;
    for (int t = 0; t < 20 && got; t++) begin
      if (t > 0) @(negedge clk);
      if (bus_b.CAN_ALE) ale_n++;
      if (!bus_b.CAN_WR_N && !bus_b.CAN_CS2_N && bus_b.CAN_AD_O == 8'h44) strb_n++;
      if (bus_b.R0_DONE) begin
        done_t = t;
        break;
      end
    end
    check("b_done_latency", 32'(done_t), 32'(B_LAT));
    check("b_ale_cycles", 32'(ale_n), 32'd2);
    check("b_strobe_cycles", 32'(strb_n), 32'd1);
    repeat (3) @(negedge clk);

    check("a_bus_invariants", 32'(inv_bad_a), 32'd0);
    check("b_bus_invariants", 32'(inv_bad_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
